mc_ctrl_fsm_v2: RTL and testbench
=================================

Name: mc_ctrl_fsm_v2

Overview:
Parametrised multicycle control FSM, next generation of the current control unit, sitting between the instruction register and the datapath muxes, PC, register file and memory. Adds a memory request/ready handshake with wait states, a wait-state timeout, and sticky HALT/TRAP states that replace simulation-only termination. Also reports illegal opcodes and exposes its state for debug.

Parameters:
MEM_TIMEOUT, 16, max consecutive not-ready cycles in any memory wait state; 0 disables timeout
TO_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2^TO_W
HALT_OP, 6'b111111, opcode that enters HALT
PERF_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op  in  6  instruction opcode [31:26]
funct  in  6  instruction funct [5:0]
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
PCWriteCond  out  1  conditional PC write (branch)
PCWrite  out  1  unconditional PC write
PCSource  out  2  00 ALU result, 10 jump target, 11 rs value
MemRead  out  1  memory read
MemWrite  out  1  memory write
Mem2Reg  out  2  00 ALU, 01 memory, 10 PC
IRWrite  out  1  instruction register load
RegDst  out  2  00 rt, 01 rd, 10 r31
RegWrite  out  1  register file write
ALU_A  out  2  00 PC, 01 rs, 10 shamt
ALU_B  out  2  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
ALUCtrlOp  out  2  00 add, 10 R-type, 11 I-type
halted  out  1  in HALT
trap  out  1  in TRAP
trap_cause  out  2  01 illegal opcode, 10 memory timeout
state_o  out  4  current state encoding
retired  out  PERF_W  instructions retired
stall_cyc  out  PERF_W  memory wait cycles

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Reset takes effect only on a rising clk edge with rst=1.
- On reset: state=FETCH, wait counter=0, trap_cause=00, counters=0.
- While rst=1, all outputs are 0.
- Control outputs are combinational from the current state, op, funct and mem_ready. Every output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXE 6, R_WB 7, BRANCH 8, JUMP 9, I_EXE 10, I_WB 11, HALT 12, TRAP 13.
- FETCH:
  - Drives mem_req=1, MemRead=1, ALU_A=00, ALU_B=01, add.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; that cycle moves to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: ALU_A=00, ALU_B=11, add. Next state by op/funct:
  - R-type with funct 0x08/0x09 -> JUMP; other R-type -> R_EXE.
  - addi/addiu/andi/ori/xori/lui/slti/sltiu -> I_EXE.
  - lb/lbu/lh/lhu/lw/sb/sh/sw -> MEM_ADDR.
  - beq/bne/blez/bgtz/0x01 -> BRANCH.
  - j/jal -> JUMP.
  - HALT_OP -> HALT.
  - Anything else -> TRAP with cause 01.
- MEM_ADDR: ALU_A=01, ALU_B=10, add. Loads -> MEM_RD; stores -> MEM_WR.
- MEM_RD: mem_req=1, MemRead=1, same ALU setting as MEM_ADDR. Waits for mem_ready, then -> MEM_WB.
- MEM_WB: RegWrite=1, Mem2Reg=01, RegDst=00 -> FETCH.
- MEM_WR: mem_req=1, MemWrite=1, same ALU setting as MEM_ADDR. Held until mem_ready; -> FETCH on the ready cycle.
- R_EXE: ALU_B=00, ALUCtrlOp=10. ALU_A=10 for funct 0x00/0x02/0x03, else 01. -> R_WB.
- R_WB: RegWrite=1, RegDst=01, Mem2Reg=00 -> FETCH.
- I_EXE: ALU_A=01, ALU_B=10, ALUCtrlOp=11 -> I_WB.
- I_WB: RegWrite=1, RegDst=00 -> FETCH.
- BRANCH: PCWriteCond=1, PCSource=00, ALU_A=00, ALU_B=11 -> FETCH.
- JUMP:
  - PCWrite=1. PCSource=11 for R-type, 10 otherwise.
  - jal: RegWrite=1, Mem2Reg=10, RegDst=10.
  - jalr: RegWrite=1, Mem2Reg=10, RegDst=01.
  - j/jr: no register write.
  - -> FETCH.
- Wait counter:
  - Increments on each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on any cycle with mem_ready=1 and on leaving those states.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1 while mem_ready=0, the next state is TRAP with cause 10. mem_ready=1 in that same cycle wins: normal completion.
- HALT and TRAP are sticky; only rst exits them. All control outputs are 0.
  - halted=1 in HALT; trap=1 in TRAP.
  - trap_cause is latched on entry and held.
- op and funct must be stable from DECODE until the instruction completes; IR is not rewritten outside FETCH.

Optional Feature:
CU_PERF_CNT_EN:
- Defined:
  - retired increments by 1 on each transition into FETCH from a completing state (MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP).
  - stall_cyc increments on each wait cycle (mem_req=1, mem_ready=0).
  - Both wrap modulo 2^PERF_W and are frozen in HALT/TRAP.
- Not defined: retired and stall_cyc are constant 0 and no counter logic is built.

Test Plan:
- Reset, then addi (op 0x08) with mem_ready=1 always -> states 0,1,10,11,0; RegWrite=1 only in I_WB; retired=1 (macro on).
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEM_RD -> IRWrite pulses once, on the ready cycle; MEM_WB asserts RegWrite with Mem2Reg=01; stall_cyc=5.
- sw with mem_ready never high, MEM_TIMEOUT=16 -> exactly 16 cycles in MEM_WR, then TRAP, trap_cause=10, MemWrite=0 afterwards.
- jal then jalr (funct 0x09) -> JUMP: PCSource=10/RegDst=10 then PCSource=11/RegDst=01; jr gives RegWrite=0.
- op 0x3F -> HALT, halted=1, state_o=12 for 20 cycles; rst pulse -> FETCH, outputs 0 during reset.
- op 0x3A (illegal) -> TRAP cause 01. rst asserted mid MEM_RD wait -> next cycle state_o=0, counters cleared.

Source files
------------

// File: rtl/mc_ctrl_fsm_v2.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_v2
//
// Multicycle control FSM that sits between the instruction register and the
// datapath (muxes, PC, register file, memory). Memory accesses use a
// request/ready handshake with wait states, and a wait-state timeout. HALT and
// TRAP are sticky terminal states that only rst leaves.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive not-ready cycles in a memory wait state
//                (0 disables the timeout)
//   TO_W         width of the wait counter (MEM_TIMEOUT < 2**TO_W)
//   HALT_OP      opcode that enters HALT
//   PERF_W       width of the performance counters
//
// Optional build macro:
//   CU_PERF_CNT_EN  builds the retired / stall_cyc performance counters;
//                   when undefined both outputs are constant 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   op, funct         opcode [31:26] and funct [5:0] from the IR
//   mem_ready         memory completes the current request this cycle
//   mem_req           memory request valid
//   PCWriteCond, PCWrite, PCSource       PC update controls
//   MemRead, MemWrite                    memory controls
//   Mem2Reg, IRWrite, RegDst, RegWrite   register file / IR controls
//   ALU_A, ALU_B, ALUCtrlOp              ALU operand and operation selects
//   halted, trap, trap_cause             terminal state status
//   state_o                              current state encoding (debug)
//   retired, stall_cyc                   performance counters
// ---------------------------------------------------------------------------
module mc_ctrl_fsm_v2 #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 8,
   parameter logic [5:0]  HALT_OP     = 6'b111111,
   parameter int unsigned PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              PCWriteCond,
   output logic              PCWrite,
   output logic [1:0]        PCSource,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [1:0]        Mem2Reg,
   output logic              IRWrite,
   output logic [1:0]        RegDst,
   output logic              RegWrite,
   output logic [1:0]        ALU_A,
   output logic [1:0]        ALU_B,
   output logic [1:0]        ALUCtrlOp,
   output logic              halted,
   output logic              trap,
   output logic [1:0]        trap_cause,
   output logic [3:0]        state_o,
   output logic [PERF_W-1:0] retired,
   output logic [PERF_W-1:0] stall_cyc
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXE    = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXE    = 4'd10,
      S_I_WB     = 4'd11,
      S_HALT     = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   wait_q, wait_d;
   logic [1:0]        cause_q, cause_d;

   logic isRtype, isJr, isItype, isLoad, isStore, isBranch, isJump;
   logic waitState, timeoutHit;

   assign isRtype  = (op == 6'h00);
   assign isJr     = isRtype && ((funct == 6'h08) || (funct == 6'h09));
   assign isItype  = (op inside {[6'h08:6'h0F]});
   assign isLoad   = (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
   assign isStore  = (op inside {6'h28, 6'h29, 6'h2B});
   assign isBranch = (op inside {6'h01, [6'h04:6'h07]});
   assign isJump   = (op inside {6'h02, 6'h03});

   // The timeout fires on the cycle the counter already holds MEM_TIMEOUT-1
   // not-ready cycles and this one is not ready either, so a wait state lasts
   // at most MEM_TIMEOUT cycles. A ready in that same cycle completes normally.
   assign waitState  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign timeoutHit = (MEM_TIMEOUT != 0) && waitState && !mem_ready &&
                       (wait_q == TO_W'(MEM_TIMEOUT - 1));

   // Next-state and trap cause selection.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeoutHit) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_DECODE: begin
            if (op == HALT_OP)              state_d = S_HALT;
            else if (isRtype)               state_d = isJr ? S_JUMP : S_R_EXE;
            else if (isItype)               state_d = S_I_EXE;
            else if (isLoad || isStore)     state_d = S_MEM_ADDR;
            else if (isBranch)              state_d = S_BRANCH;
            else if (isJump)                state_d = S_JUMP;
            else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_MEM_ADDR: state_d = isStore ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD, S_MEM_WR: begin
            if (mem_ready) begin
               state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            end else if (timeoutHit) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_R_EXE:  state_d = S_R_WB;
         S_I_EXE:  state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT, S_TRAP: state_d = state_q;
         default:  state_d = S_FETCH;
      endcase
   end

   // Wait counter counts consecutive not-ready cycles while staying in the
   // same wait state; any ready or state change clears it.
   always_comb begin
      wait_d = '0;
      if (waitState && !mem_ready && (state_d == state_q)) begin
         wait_d = wait_q + TO_W'(1);
      end
   end

   // State, wait counter and trap cause registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   // Control outputs decoded from the current state; everything is forced
   // low while rst is held so the datapath sees no spurious writes.
   always_comb begin
      mem_req     = 1'b0;
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      PCSource    = 2'b00;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Mem2Reg     = 2'b00;
      IRWrite     = 1'b0;
      RegDst      = 2'b00;
      RegWrite    = 1'b0;
      ALU_A       = 2'b00;
      ALU_B       = 2'b00;
      ALUCtrlOp   = 2'b00;
      halted      = 1'b0;
      trap        = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               MemRead = 1'b1;
               ALU_B   = 2'b01;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end
            end
            S_DECODE: ALU_B = 2'b11;
            S_MEM_ADDR: begin
               ALU_A = 2'b01;
               ALU_B = 2'b10;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               MemRead = 1'b1;
               ALU_A   = 2'b01;
               ALU_B   = 2'b10;
            end
            S_MEM_WB: begin
               RegWrite = 1'b1;
               Mem2Reg  = 2'b01;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               MemWrite = 1'b1;
               ALU_A    = 2'b01;
               ALU_B    = 2'b10;
            end
            S_R_EXE: begin
               ALUCtrlOp = 2'b10;
               ALU_A     = (funct inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
            end
            S_R_WB: begin
               RegWrite = 1'b1;
               RegDst   = 2'b01;
            end
            S_I_EXE: begin
               ALU_A     = 2'b01;
               ALU_B     = 2'b10;
               ALUCtrlOp = 2'b11;
            end
            S_I_WB: RegWrite = 1'b1;
            S_BRANCH: begin
               PCWriteCond = 1'b1;
               ALU_B       = 2'b11;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = isRtype ? 2'b11 : 2'b10;
               if (op == 6'h03) begin
                  RegWrite = 1'b1;
                  Mem2Reg  = 2'b10;
                  RegDst   = 2'b10;
               end else if (isRtype && (funct == 6'h09)) begin
                  RegWrite = 1'b1;
                  Mem2Reg  = 2'b10;
                  RegDst   = 2'b01;
               end
            end
            S_HALT:  halted = 1'b1;
            S_TRAP:  trap   = 1'b1;
            default: ;
         endcase
      end
   end

   assign state_o    = rst ? 4'd0 : state_q;
   assign trap_cause = rst ? 2'b00 : cause_q;

`ifdef CU_PERF_CNT_EN
   logic [PERF_W-1:0] retired_q, stall_q;
   logic              retireEvt;

   // An instruction retires when a completing state hands back to FETCH.
   assign retireEvt = (state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP}) &&
                      (state_d == S_FETCH);

   // Counters wrap naturally; no events occur in HALT/TRAP so they freeze there.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (retireEvt)             retired_q <= retired_q + PERF_W'(1);
         if (mem_req && !mem_ready) stall_q   <= stall_q + PERF_W'(1);
      end
   end

   assign retired   = rst ? '0 : retired_q;
   assign stall_cyc = rst ? '0 : stall_q;
`else
   assign retired   = '0;
   assign stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm_v2
//
// Scoreboard bench for mc_ctrl_fsm_v2. A driver walks whole instructions
// (fetch wait, decode, class-specific steps, memory waits, timeouts, sticky
// HALT/TRAP) and pushes the expected per-cycle outputs into a queue; a
// separate monitor pops one entry per cycle and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm_v2;

   localparam int TO = 16;

   logic        clk, rst, mem_ready;
   logic [5:0]  op, funct;
   logic        mem_req, PCWriteCond, PCWrite, MemRead, MemWrite, IRWrite, RegWrite;
   logic        halted, trap;
   logic [1:0]  PCSource, Mem2Reg, RegDst, ALU_A, ALU_B, ALUCtrlOp, trap_cause;
   logic [3:0]  state_o;
   logic [31:0] retired, stall_cyc;

   mc_ctrl_fsm_v2 #(.MEM_TIMEOUT(TO), .TO_W(8), .HALT_OP(6'h3F), .PERF_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite),
      .PCSource(PCSource), .MemRead(MemRead), .MemWrite(MemWrite),
      .Mem2Reg(Mem2Reg), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALUCtrlOp(ALUCtrlOp), .halted(halted),
      .trap(trap), .trap_cause(trap_cause), .state_o(state_o),
      .retired(retired), .stall_cyc(stall_cyc)
   );

   typedef struct packed {
      logic [3:0]  st;
      logic        memReq, pcwc, pcw;
      logic [1:0]  pcsrc;
      logic        mrd, mwr;
      logic [1:0]  m2r;
      logic        irw;
      logic [1:0]  rdst;
      logic        rw;
      logic [1:0]  aluA, aluB, aluOp;
      logic        hlt, trp;
      logic [1:0]  cause;
      logic [31:0] ret, stl;
   } outs_t;

   outs_t       expQ[$];
   int          checks = 0;
   int          errors = 0;
   logic [5:0]  curOp = 6'h00;
   logic [5:0]  curFunct = 6'h00;
   logic [1:0]  trapCause = 2'b00;
   logic [31:0] retiredCnt = 0;
   logic [31:0] stallCnt = 0;
   bit          stuck = 0;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction classes derived straight from the opcode table.
   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h3F) return 7;
      if (o == 6'h00) return ((f == 6'h08) || (f == 6'h09)) ? 1 : 0;
      if (o inside {[6'h08:6'h0F]}) return 2;
      if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return 3;
      if (o inside {6'h28, 6'h29, 6'h2B}) return 4;
      if (o inside {6'h01, [6'h04:6'h07]}) return 5;
      if (o inside {6'h02, 6'h03}) return 6;
      return 8;
   endfunction

   // Expected output vector for one cycle spent in a given step.
   function automatic outs_t expOut(input int st, input logic [5:0] o, input logic [5:0] f,
                                    input logic rdy);
      outs_t e;
      e = '0;
      e.st = st[3:0];
      case (st)
         0:  begin e.memReq = 1; e.mrd = 1; e.aluB = 2'b01; e.irw = rdy; e.pcw = rdy; end
         1:  e.aluB = 2'b11;
         2:  begin e.aluA = 2'b01; e.aluB = 2'b10; end
         3:  begin e.memReq = 1; e.mrd = 1; e.aluA = 2'b01; e.aluB = 2'b10; end
         4:  begin e.rw = 1; e.m2r = 2'b01; end
         5:  begin e.memReq = 1; e.mwr = 1; e.aluA = 2'b01; e.aluB = 2'b10; end
         6:  begin e.aluOp = 2'b10; e.aluA = (f == 0 || f == 2 || f == 3) ? 2'b10 : 2'b01; end
         7:  begin e.rw = 1; e.rdst = 2'b01; end
         8:  begin e.pcwc = 1; e.aluB = 2'b11; end
         9:  begin
                e.pcw = 1;
                e.pcsrc = (o == 0) ? 2'b11 : 2'b10;
                if (o == 6'h03) begin e.rw = 1; e.m2r = 2'b10; e.rdst = 2'b10; end
                if (o == 6'h00 && f == 6'h09) begin e.rw = 1; e.m2r = 2'b10; e.rdst = 2'b01; end
             end
         10: begin e.aluA = 2'b01; e.aluB = 2'b10; e.aluOp = 2'b11; end
         11: e.rw = 1;
         12: e.hlt = 1;
         13: e.trp = 1;
         default: ;
      endcase
      e.cause = trapCause;
`ifdef CU_PERF_CNT_EN
      e.ret = retiredCnt;
      e.stl = stallCnt;
`endif
      return e;
   endfunction

   function automatic logic rr();
      return 1'($urandom_range(0, 1));
   endfunction

   // Drive one cycle that the model expects to be spent in step st.
   task automatic applyStimulus(input int st, input logic rdy);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      mem_ready = rdy;
      op        = curOp;
      funct     = curFunct;
      expQ.push_back(expOut(st, curOp, curFunct, rdy));
      if ((st == 0 || st == 3 || st == 5) && !rdy) stallCnt++;
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst       = 1'b1;
         mem_ready = rr();
         expQ.push_back('0);
      end
      trapCause  = 2'b00;
      retiredCnt = 0;
      stallCnt   = 0;
      stuck      = 0;
   endtask

   task automatic stick(input int st, input int n);
      for (int i = 0; i < n; i++) applyStimulus(st, rr());
   endtask

   task automatic enterTrap(input logic [1:0] c);
      trapCause = c;
      stuck     = 1;
      stick(13, 3);
   endtask

   // Memory phase: w not-ready cycles then ready, unless the timeout cuts in.
   task automatic memPhase(input int st, input int w, output bit timedOut);
      timedOut = 0;
      for (int k = 0; k <= w; k++) begin
         if (k == TO) begin
            timedOut = 1;
            break;
         end
         applyStimulus(st, (k == w));
      end
   endtask

   task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
      bit to;
      curOp    = o;
      curFunct = f;
      memPhase(0, fw, to);
      if (to) begin
         enterTrap(2'b10);
         return;
      end
      applyStimulus(1, rr());
      case (classify(o, f))
         0: begin applyStimulus(6, rr()); applyStimulus(7, rr()); retiredCnt++; end
         1, 6: begin applyStimulus(9, rr()); retiredCnt++; end
         2: begin applyStimulus(10, rr()); applyStimulus(11, rr()); retiredCnt++; end
         3: begin
               applyStimulus(2, rr());
               memPhase(3, mw, to);
               if (to) enterTrap(2'b10);
               else begin applyStimulus(4, rr()); retiredCnt++; end
            end
         4: begin
               applyStimulus(2, rr());
               memPhase(5, mw, to);
               if (to) enterTrap(2'b10);
               else retiredCnt++;
            end
         5: begin applyStimulus(8, rr()); retiredCnt++; end
         7: begin stuck = 1; stick(12, 3); end
         default: enterTrap(2'b01);
      endcase
   endtask

   function automatic int pickWait();
      if ($urandom_range(0, 99) < 6) return $urandom_range(TO - 2, TO + 2);
      return $urandom_range(0, 3);
   endfunction

   // Monitor: one scoreboard entry per cycle, compared mid-cycle.
   task automatic checkOutput();
      outs_t e, a;
      e = expQ.pop_front();
      a = '{st: state_o, memReq: mem_req, pcwc: PCWriteCond, pcw: PCWrite, pcsrc: PCSource,
            mrd: MemRead, mwr: MemWrite, m2r: Mem2Reg, irw: IRWrite, rdst: RegDst,
            rw: RegWrite, aluA: ALU_A, aluB: ALU_B, aluOp: ALUCtrlOp, hlt: halted,
            trp: trap, cause: trap_cause, ret: retired, stl: stall_cyc};
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL outputs t=%0t exp_state=%0d got=%h exp=%h", $time, e.st, a, e);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) checkOutput();
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [5:0] o, f;
      rst = 1'b1; mem_ready = 1'b0; op = 6'h00; funct = 6'h00;

      // Directed scenarios.
      doReset(2);
      runInstr(6'h08, 6'h00, 0, 0);          // addi
      runInstr(6'h23, 6'h00, 3, 2);          // lw with waits
      runInstr(6'h2B, 6'h00, 0, 100);        // sw never ready -> timeout
      doReset(1);
      runInstr(6'h03, 6'h00, 0, 0);          // jal
      runInstr(6'h00, 6'h09, 1, 0);          // jalr
      runInstr(6'h00, 6'h08, 0, 0);          // jr
      runInstr(6'h00, 6'h20, 0, 0);          // add
      runInstr(6'h00, 6'h02, 0, 0);          // srl (shamt operand)
      runInstr(6'h04, 6'h00, 0, 0);          // beq
      runInstr(6'h20, 6'h00, 0, TO - 1);     // lb completes on the last legal cycle
      runInstr(6'h3F, 6'h00, 0, 0);          // HALT
      stick(12, 17);
      doReset(2);
      runInstr(6'h3A, 6'h00, 0, 0);          // illegal
      doReset(1);
      runInstr(6'h0F, 6'h00, TO, 0);         // fetch timeout
      doReset(1);
      curOp = 6'h23; curFunct = 6'h00;       // reset in the middle of a MEM_RD wait
      applyStimulus(0, 1'b1);
      applyStimulus(1, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(3, 1'b0);
      applyStimulus(3, 1'b0);
      doReset(1);

      // Randomized instruction stream.
      for (int n = 0; n < 250; n++) begin
         int r;
         r = $urandom_range(0, 99);
         f = 6'($urandom_range(0, 63));
         if (r < 2) o = 6'h3F;
         else if (r < 4) begin
            do o = 6'($urandom_range(0, 63)); while (classify(o, 6'h00) != 8);
         end else begin
            do o = 6'($urandom_range(0, 63)); while (classify(o, 6'h00) == 8 || o == 6'h3F);
            if ($urandom_range(0, 3) == 0) o = 6'h00;
            if (o == 6'h00 && $urandom_range(0, 3) == 0) f = 6'h08 + 6'($urandom_range(0, 1));
         end
         runInstr(o, f, pickWait(), pickWait());
         if (stuck) doReset($urandom_range(1, 2));
      end

      repeat (2) @(posedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain left=%0d required=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
